// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 keypad matrix model that answers a column scanner with active-low rows,
// replaying key indices queued through a valid/ready port.
module keypad_emulator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int RELEASE_CYCLES = 16,
  parameter int WAIT_LIMIT     = 64
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       key_valid,
  input  logic [3:0] key_idx,
  output logic       key_ready,
  input  logic [3:0] ColOut,
  output logic [3:0] RowIn,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic [7:0] keys_sent
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int M1   = WAIT_LIMIT > HOLD_CYCLES ? WAIT_LIMIT : HOLD_CYCLES;
  localparam int CMAX = M1 > RELEASE_CYCLES ? M1 : RELEASE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_LIMIT - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_MAX  = CW'(RELEASE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT_COL, PRESS, RELEASE} state_t;
  state_t state, state_nx;
  logic [3:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop;
  logic [3:0] cur_key;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] row, col;
  logic col_act, col_match, hit_timeout, hit_sent;
  assign row       = cur_key[3:2];
  assign col       = cur_key[1:0];
  assign col_act   = !ColOut[col];
  assign col_match = ColOut == ~(4'b0001 << col);
  assign push      = key_valid && !full;
  assign key_ready = !full;
  assign busy      = state != IDLE || !empty;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= key_idx;
  // Flags are registered; the pointer comparison looks one step ahead so they stay exact.
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        empty <= 1'b0;
        full  <= wr_ptr + AW'(1) == rd_ptr;
      end else if (pop && !push) begin
        full  <= 1'b0;
        empty <= rd_ptr + AW'(1) == wr_ptr;
      end
    end
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pop         = 1'b0;
    hit_timeout = 1'b0;
    hit_sent    = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop      = 1'b1;
          cnt_nx   = '0;
          state_nx = WAIT_COL;
        end
      WAIT_COL:
        if (col_match) begin
          cnt_nx   = '0;
          state_nx = PRESS;
        end else if (cnt == WAIT_MAX) begin
          hit_timeout = 1'b1;
          state_nx    = IDLE;
        end else cnt_nx = cnt + 1'b1;
      // Hold time only advances while our column is driven, so it spans scan sweeps.
      PRESS:
        if (col_act) begin
          if (cnt == HOLD_MAX) begin
            hit_sent = 1'b1;
            cnt_nx   = '0;
            state_nx = RELEASE;
          end else cnt_nx = cnt + 1'b1;
        end
      RELEASE:
        if (cnt == REL_MAX) state_nx = IDLE;
        else cnt_nx = cnt + 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_key     <= '0;
      timeout_err <= 1'b0;
      keys_sent   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (pop) cur_key <= mem[rd_ptr];
      if (hit_timeout) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (hit_sent) keys_sent <= keys_sent + 8'd1;
    end
  always_comb begin
    RowIn = 4'hF;
    if (state == PRESS) RowIn[row] = ColOut[col];
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed scenarios plus randomized scanning, checked every cycle
// against a queue-and-countdown model of the keypad behaviour.
module tb_keypad_emulator;
  localparam int DEPTH = 4, HOLD = 8, REL = 16, WLIM = 64;
  localparam int P_IDLE = 0, P_WAIT = 1, P_PRESS = 2, P_REL = 3;
  logic clk = 1'b0, nRST = 1'b0, key_valid = 1'b0, err_clr = 1'b0;
  logic [3:0] key_idx = 4'h0, ColOut = 4'hF;
  logic key_ready, busy, timeout_err;
  logic [3:0] RowIn;
  logic [7:0] keys_sent;
  int checks = 0, errors = 0;
  keypad_emulator #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .RELEASE_CYCLES(REL), .WAIT_LIMIT(WLIM)) dut (
    .clk(clk), .nRST(nRST), .key_valid(key_valid), .key_idx(key_idx), .key_ready(key_ready),
    .ColOut(ColOut), .RowIn(RowIn), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
    .keys_sent(keys_sent)
  );
  always #5 clk = ~clk;
  logic [3:0] mq [$];
  int phase = P_IDLE, waited = 0, held = 0, rel = 0;
  logic [3:0] cur = 4'h0;
  logic m_err = 1'b0;
  logic [7:0] m_sent = 8'd0;
  logic [3:0] obs_row;
  logic obs_ready, obs_err;
  logic [7:0] obs_sent;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] exp_row();
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++)
      if (phase == P_PRESS && i == int'(cur[3:2])) r[i] = ColOut[cur[1:0]];
    return r;
  endfunction
  task automatic compare_all();
    obs_row = RowIn;
    obs_ready = key_ready;
    obs_err = timeout_err;
    obs_sent = keys_sent;
    check("rowin", 32'(RowIn), 32'(exp_row()));
    check("key_ready", 32'(key_ready), 32'(mq.size() < DEPTH));
    check("busy", 32'(busy), 32'(phase != P_IDLE || mq.size() > 0));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("keys_sent", 32'(keys_sent), 32'(m_sent));
  endtask
  task automatic model_update();
    bit push_ok, tmo;
    push_ok = key_valid && mq.size() < DEPTH;
    tmo = 1'b0;
    case (phase)
      P_IDLE:
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          phase = P_WAIT;
          waited = 0;
        end
      P_WAIT:
        if ($countones(ColOut) == 3 && !ColOut[cur[1:0]]) begin
          phase = P_PRESS;
          held = 0;
        end else begin
          waited++;
          if (waited == WLIM) begin
            tmo = 1'b1;
            phase = P_IDLE;
          end
        end
      P_PRESS:
        if (!ColOut[cur[1:0]]) begin
          held++;
          if (held == HOLD) begin
            m_sent++;
            phase = P_REL;
            rel = 0;
          end
        end
      default: begin
        rel++;
        if (rel == REL) phase = P_IDLE;
      end
    endcase
    if (tmo) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (push_ok) mq.push_back(key_idx);
  endtask
  task automatic step(input logic [3:0] c, input logic v, input logic [3:0] k, input logic clr);
    @(negedge clk);
    ColOut = c;
    key_valid = v;
    key_idx = k;
    err_clr = clr;
    #1 compare_all();
    @(posedge clk);
    model_update();
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    check({tag, "_rst_row"}, 32'(RowIn), 32'hF);
    check({tag, "_rst_ready"}, 32'(key_ready), 32'h1);
    check({tag, "_rst_busy"}, 32'(busy), 32'h0);
    check({tag, "_rst_err"}, 32'(timeout_err), 32'h0);
    check({tag, "_rst_sent"}, 32'(keys_sent), 32'h0);
    mq.delete();
    phase = P_IDLE;
    waited = 0;
    held = 0;
    rel = 0;
    cur = 4'h0;
    m_err = 1'b0;
    m_sent = 8'd0;
    @(negedge clk);
    key_valid = 1'b0;
    err_clr = 1'b0;
    nRST = 1'b1;
  endtask
  initial begin
    int hits, bad, first, last, f_after, acc, first_err;
    logic [3:0] c;
    do_reset("init");
    // rotating scanner, key 2 = row 0 col 2
    hits = 0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      c = ~(4'b0001 << (i % 4));
      step(c, i == 0, 4'd2, 1'b0);
      if (obs_row == 4'b1110) begin
        hits++;
        if (ColOut != 4'b1011) bad++;
      end else if (obs_row != 4'hF) bad++;
    end
    check("rot_press_cycles", 32'(hits), 32'd8);
    check("rot_wrong_col", 32'(bad), 32'd0);
    check("rot_sent", 32'(obs_sent), 32'd1);
    // frozen scanner on column 3, key 15
    do_reset("frz");
    hits = 0;
    first = -1;
    last = -1;
    f_after = 0;
    for (int i = 0; i < 60; i++) begin
      step(4'b0111, i == 0, 4'd15, 1'b0);
      if (obs_row == 4'b0111) begin
        hits++;
        if (first < 0) first = i;
        last = i;
      end else if (hits == HOLD && obs_row == 4'hF) f_after++;
    end
    check("frz_press_cycles", 32'(hits), 32'd8);
    check("frz_contiguous", 32'(last - first + 1), 32'd8);
    check("frz_release_ge16", 32'(f_after >= 16), 32'd1);
    check("frz_sent", 32'(obs_sent), 32'd1);
    // reset during a press must drop the row at once
    do_reset("mid");
    for (int i = 0; i < 6; i++) step(4'b1110, i == 0, 4'd0, 1'b0);
    #1 check("mid_pressed_row", 32'(RowIn), 32'hE);
    do_reset("midpress");
    // queue full with the scanner idle
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'hF, 1'b1, 4'(i + 1), 1'b0);
      check("qfull_ready", 32'(obs_ready), 32'(i < 5));
      if (obs_ready) acc++;
    end
    check("qfull_accepted", 32'(acc), 32'd5);
    // timeout on key 4, then key 5 proceeds on column 1
    do_reset("tmo");
    step(4'hF, 1'b1, 4'd4, 1'b0);
    step(4'hF, 1'b1, 4'd5, 1'b0);
    first_err = -1;
    for (int j = 2; j < 120; j++) begin
      step(first_err < 0 ? 4'hF : 4'b1101, 1'b0, 4'd0, 1'b0);
      if (first_err < 0 && obs_err) begin
        first_err = j;
        check("tmo_sent_unchanged", 32'(obs_sent), 32'd0);
      end
    end
    check("tmo_rise_step", 32'(first_err), 32'd66);
    check("tmo_next_key_sent", 32'(obs_sent), 32'd1);
    check("tmo_sticky", 32'(obs_err), 32'd1);
    step(4'hF, 1'b0, 4'd0, 1'b1);
    step(4'hF, 1'b0, 4'd0, 1'b0);
    check("tmo_cleared", 32'(obs_err), 32'd0);
    // randomized scanning and key traffic
    do_reset("rnd");
    for (int n = 0; n < 3000;) begin
      int mode, len, fc;
      mode = $urandom_range(0, 3);
      len = $urandom_range(10, 150);
      fc = $urandom_range(0, 3);
      for (int i = 0; i < len; i++, n++) begin
        case (mode)
          0: c = ~(4'b0001 << ((n + fc) % 4));
          1: c = ~(4'b0001 << fc);
          2: c = 4'hF;
          default: c = 4'($urandom);
        endcase
        step(c, $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 15) == 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable 4x4 keypad matrix model that sits on the keypad side of the calculator's column-scan interface. It observes the active-low column scan `ColOut` and drives the active-low row return `RowIn`, just as a physical key press would. Key indices are queued through a valid/ready port. This allows on-chip self-test and loopback of `calculator_top` without a physical keypad, and reuses the scanner protocol unchanged.

## Interface
- `FIFO_DEPTH`, default 4: key request queue depth, power of two, at least 2.
- `HOLD_CYCLES`, default 8: number of cycles the key stays closed while its column is active.
- `RELEASE_CYCLES`, default 16: idle cycles after release before the next key.
- `WAIT_LIMIT`, default 64: cycles allowed for the target column to appear before timeout.
- `clk`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `key_valid`  in  1  key request strobe.
- `key_idx`  in  4  key index; row = `key_idx[3:2]`, col = `key_idx[1:0]`.
- `key_ready`  out  1  queue not full; a push happens when `key_valid && key_ready`.
- `ColOut`  in  4  scanner column drive, one-cold when scanning, `4'b1111` when idle.
- `RowIn`  out  4  row return to scanner, active low.
- `busy`  out  1  high whenever the state is not IDLE or the queue is non-empty.
- `timeout_err`  out  1  sticky error flag; set on a wait timeout.
- `err_clr`  in  1  synchronous clear of `timeout_err`.
- `keys_sent`  out  8  count of completed presses; wraps from 255 to 0.

## Operation
- **Queue:** synchronous FIFO with registered full and empty flags.
  - `key_ready = !full`.
  - A push on a full queue is not accepted; the requester holds `key_valid`.
  - A push and a pop in the same cycle are both legal.
- **FSM states:** IDLE, WAIT_COL, PRESS, RELEASE.
- **IDLE:**
  - `RowIn = 1111`.
  - If the queue is non-empty: pop into `cur_key`, clear the counter, go to WAIT_COL.
- **WAIT_COL:**
  - `RowIn = 1111`.
  - Match condition: `ColOut == ~(4'b0001 << col)`.
  - On match: go to PRESS and clear the counter.
  - Otherwise increment the counter. When it reaches `WAIT_LIMIT-1`:
    - set `timeout_err`;
    - drop the key (`keys_sent` is unchanged);
    - go to IDLE.
- **PRESS:** models a closed contact.
  - `RowIn[row] = ColOut[col]` combinationally; all other rows are 1.
  - The counter increments on each cycle with the column active (`ColOut[col] == 0`). Cycles spent on other columns do not count, but accumulate across scan sweeps.
  - When the count reaches `HOLD_CYCLES-1` on an active cycle: go to RELEASE and increment `keys_sent`.
- **RELEASE:**
  - `RowIn = 1111`.
  - Count `RELEASE_CYCLES` cycles, then go to IDLE.
- **Error flag:**
  - `err_clr` clears `timeout_err`.
  - If a set and a clear occur in the same cycle, the set wins.
- **Invalid ColOut:** a value with more than one zero never matches in WAIT_COL. In PRESS the combinational path is still applied.

## Timing
- **Reset values:**
  - state IDLE, queue empty;
  - `RowIn = 1111`, `key_ready = 1`, `busy = 0`, `timeout_err = 0`, `keys_sent = 0`.
  - `RowIn` returns to `1111` immediately on `nRST` assertion, mid-press included.
- **Push to pop latency:** a key pushed at edge N is popped at edge N+1 when idle, giving WAIT_COL from edge N+1.
- **WAIT_COL to PRESS:** the match is evaluated on registered state, so PRESS begins at the edge after `ColOut` matches. `RowIn` asserts in that first PRESS cycle if the column is still active.
- **RowIn in PRESS:** zero-cycle path from `ColOut`. There is no register between them.
- **Key-to-key minimum gap:** `RELEASE_CYCLES + 1` cycles from the PRESS exit to the next WAIT_COL.
- **keys_sent update:** registered, visible the cycle after the final hold cycle.

## Test plan
- **Reset:** assert `nRST` mid-operation.
  - Required: `RowIn = 1111`, `key_ready = 1`, `busy = 0`, `keys_sent = 0`, `timeout_err = 0` asynchronously.
- **Single key with a rotating scanner:**
  - Stimulus: `ColOut` cycles 1110, 1101, 1011, 0111, one cycle each; push `key_idx = 2`.
  - Required: `RowIn = 1110` only while `ColOut = 1011`, for 8 such cycles total; then `1111`; `keys_sent = 1`.
- **Frozen scanner:**
  - Stimulus: `ColOut` held at 0111; push key 15.
  - Required: `RowIn = 0111` for exactly 8 consecutive cycles, then `1111` for 16 or more cycles; `keys_sent = 1`.
- **Queue full:**
  - Stimulus: `ColOut = 1111`; push with `key_valid` held over 6 consecutive cycles.
  - Required: 5 keys accepted (1 popped plus 4 queued); `key_ready = 0` from the cycle after the 5th push.
- **Timeout:**
  - Stimulus: `ColOut = 1111`; push key 4.
  - Required: `timeout_err` rises 64 cycles after entering WAIT_COL; `keys_sent` is unchanged; the next queued key proceeds; `err_clr` drops the flag.
- **Calculator loopback:**
  - Stimulus: connect to `calculator_top` and push 2, 11, 4, 12 (3 × 4 =).
  - Required: `complete = 1` and `display_output = 12`.
